// File: rtl/user_wr_packer.sv
// user_wr_packer: packs narrow user words into wide beats, buffers the beats and
// drains them as fixed-length write bursts over a sequential, wrapping frame.
// Latency: a beat enters the buffer 1 cycle after its last word is accepted;
// a burst is requested once P_BURST_LEN beats are buffered.
// Backpressure: none toward the user. A beat that finds the buffer full is
// dropped and o_overflow latches high. The write side stalls beats on i_wr_ready.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-low reset
//   i_user_data / i_user_valid       user word stream (always accepted)
//   o_wr_req/o_wr_addr/o_wr_len      burst request, held until i_wr_ack
//   o_wr_data/o_wr_valid/o_wr_last   write beats, accepted on i_wr_ready
//   o_overflow                       sticky beat-drop flag

// Generic FIFO used as the beat buffer.
// Latency: head visible the cycle after push into an empty FIFO.
// Backpressure: push into a full FIFO is ignored unless a pop happens that cycle.
module user_wr_packer_fifo #(
  parameter int P_WIDTH = 128,
  parameter int P_DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [P_WIDTH-1:0]        push_dat,
  input  logic                      pop,
  output logic [P_WIDTH-1:0]        head_dat,
  output logic [$clog2(P_DEPTH):0]  count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(P_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module user_wr_packer #(
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_DATA_WIDTH  = 128,
  parameter int P_AXI_ADDR_WIDTH  = 32,
  parameter int P_WR_LENGTH       = 4096,
  parameter int P_BURST_LEN       = 16,
  parameter int P_FIFO_DEPTH      = 64,
  parameter int P_BASE_ADDR       = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_USER_DATA_WIDTH-1:0] i_user_data,
  input  logic                         i_user_valid,
  output logic                         o_wr_req,
  output logic [P_AXI_ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [7:0]                   o_wr_len,
  input  logic                         i_wr_ack,
  output logic [P_AXI_DATA_WIDTH-1:0]  o_wr_data,
  output logic                         o_wr_valid,
  output logic                         o_wr_last,
  input  logic                         i_wr_ready,
  output logic                         o_overflow
);
  localparam int R   = P_AXI_DATA_WIDTH / P_USER_DATA_WIDTH;
  localparam int PCW = (R > 1) ? $clog2(R) : 1;
  localparam int BCW = (P_BURST_LEN > 1) ? $clog2(P_BURST_LEN) : 1;
  localparam int CW  = $clog2(P_FIFO_DEPTH) + 1;

  localparam logic [P_AXI_ADDR_WIDTH-1:0] BASE_ADDR   = P_AXI_ADDR_WIDTH'(P_BASE_ADDR);
  localparam logic [P_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    P_AXI_ADDR_WIDTH'(P_BURST_LEN * (P_AXI_DATA_WIDTH / 8));
  localparam logic [P_AXI_ADDR_WIDTH-1:0] FRAME_END   =
    P_AXI_ADDR_WIDTH'(P_BASE_ADDR + P_WR_LENGTH * (P_USER_DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------- packing ----------------
  logic [PCW-1:0]              pack_cnt;
  logic [P_AXI_DATA_WIDTH-1:0] pack_buf;
  logic [P_AXI_DATA_WIDTH-1:0] pack_nxt;
  logic [P_AXI_DATA_WIDTH-1:0] beat_dat;
  logic                        beat_vld;
  logic                        pack_done;

  assign pack_done = i_user_valid && (pack_cnt == PCW'(R - 1));

  // Current word dropped into its lane; earlier lanes come from pack_buf.
  always_comb begin
    pack_nxt = pack_buf;
    for (int k = 0; k < R; k++) begin
      if (pack_cnt == PCW'(k)) begin
        pack_nxt[k*P_USER_DATA_WIDTH +: P_USER_DATA_WIDTH] = i_user_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pack_cnt <= '0;
      pack_buf <= '0;
      beat_dat <= '0;
      beat_vld <= 1'b0;
    end else begin
      beat_vld <= pack_done;
      if (i_user_valid) begin
        pack_buf <= pack_nxt;
        pack_cnt <= pack_done ? '0 : pack_cnt + 1'b1;
      end
      if (pack_done) beat_dat <= pack_nxt;
    end
  end

  // ---------------- beat buffer ----------------
  logic [P_AXI_DATA_WIDTH-1:0] head_dat;
  logic [CW-1:0]               fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        beat_acc;

  assign beat_acc = o_wr_valid && i_wr_ready;

  user_wr_packer_fifo #(
    .P_WIDTH (P_AXI_DATA_WIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .push     (beat_vld),
    .push_dat (beat_dat),
    .pop      (beat_acc),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overflow <= 1'b0;
    end else if (beat_vld && fifo_full && !beat_acc) begin
      o_overflow <= 1'b1;
    end
  end

  // ---------------- burst control ----------------
  logic [BCW-1:0]              beat_cnt;
  logic [P_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic                        last_beat;

  assign last_beat = (beat_cnt == BCW'(P_BURST_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The burst is only entered with a full burst buffered, so valid stays high
  // throughout DATA; the empty gate just keeps the handshake honest.
  always_comb begin
    state_nxt  = state;
    o_wr_req   = 1'b0;
    o_wr_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count >= CW'(P_BURST_LEN)) state_nxt = S_REQ;
      end
      S_REQ: begin
        o_wr_req = 1'b1;
        if (i_wr_ack) state_nxt = S_DATA;
      end
      S_DATA: begin
        o_wr_valid = !fifo_empty;
        if (!fifo_empty && i_wr_ready && last_beat) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      beat_cnt <= '0;
      wr_addr  <= BASE_ADDR;
    end else if (beat_acc) begin
      if (last_beat) begin
        beat_cnt <= '0;
        // Frame is a whole number of bursts; wrap when the next burst would start at frame end.
        if (wr_addr + BURST_BYTES == FRAME_END) wr_addr <= BASE_ADDR;
        else                                    wr_addr <= wr_addr + BURST_BYTES;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign o_wr_addr = wr_addr;
  assign o_wr_len  = 8'(P_BURST_LEN - 1);
  assign o_wr_last = o_wr_valid && last_beat;
  // Zero outside DATA so nothing stale from the buffer RAM leaks out.
  assign o_wr_data = o_wr_valid ? head_dat : '0;
endmodule

// File: tb/tb_user_wr_packer.sv
// Bench for user_wr_packer: directed stimulus, an abstract queue-based model
// checked every cycle, and hand-computed literal expectations.
module tb_user_wr_packer;
  localparam int R     = 8;
  localparam int BL    = 16;
  localparam int DEPTH = 64;
  localparam int NB    = 32;   // bursts per frame: 4096*2 bytes / 256 bytes
  localparam int BB    = 256;  // bytes per burst

  logic         clk;
  logic         rst_n;
  logic [15:0]  user_data;
  logic         user_valid;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [7:0]   wr_len;
  logic         wr_ack;
  logic [127:0] wr_data;
  logic         wr_valid;
  logic         wr_last;
  logic         wr_ready;
  logic         overflow;

  user_wr_packer dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_user_data  (user_data),
    .i_user_valid (user_valid),
    .o_wr_req     (wr_req),
    .o_wr_addr    (wr_addr),
    .o_wr_len     (wr_len),
    .i_wr_ack     (wr_ack),
    .o_wr_data    (wr_data),
    .o_wr_valid   (wr_valid),
    .o_wr_last    (wr_last),
    .i_wr_ready   (wr_ready),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [127:0] m_q[$];
  int           m_phase;      // 0 waiting for a full burst, 1 requesting, 2 transferring
  int           m_beats;
  int           m_burst;
  bit           m_ovf;
  logic [127:0] m_lanes;
  int           m_wcnt;
  bit           m_pend;
  logic [127:0] m_pend_beat;
  bit           m_pop;
  bit           m_last_acc;
  int           m_size0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_phase = 0; m_beats = 0; m_burst = 0; m_ovf = 0;
        m_lanes = '0; m_wcnt = 0; m_pend = 0; m_pend_beat = '0;
      end else begin
        m_size0    = m_q.size();
        m_pop      = (m_phase == 2) && (m_size0 > 0) && wr_ready;
        m_last_acc = m_pop && (m_beats == BL - 1);
        if (m_pop) begin
          void'(m_q.pop_front());
          m_beats = m_last_acc ? 0 : m_beats + 1;
        end
        if (m_pend) begin
          if (m_size0 == DEPTH && !m_pop) m_ovf = 1;
          else m_q.push_back(m_pend_beat);
        end
        case (m_phase)
          0: if (m_size0 >= BL) m_phase = 1;
          1: if (wr_ack) m_phase = 2;
          default: if (m_last_acc) begin
            m_phase = 0;
            m_burst = (m_burst + 1) % NB;
          end
        endcase
        m_pend = 0;
        if (user_valid) begin
          m_lanes[m_wcnt*16 +: 16] = user_data;
          m_wcnt++;
          if (m_wcnt == R) begin
            m_pend = 1;
            m_pend_beat = m_lanes;
            m_wcnt = 0;
          end
        end
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic [127:0] acc_dat[$];
  bit           acc_lst[$];
  logic [31:0]  req_addr[$];
  bit           prev_stall;
  logic [127:0] prev_dat;
  logic         prev_last;
  int           n_stall_seen;
  bit           exp_vld;

  initial begin
    prev_stall = 0; n_stall_seen = 0;
    forever begin
      @(negedge clk);
      #1;
      exp_vld = (m_phase == 2) && (m_q.size() > 0);
      chk("req",      wr_req,   m_phase == 1);
      chk("valid",    wr_valid, exp_vld);
      chk("overflow", overflow, m_ovf);
      chk("len",      wr_len,   8'd15);
      chk("addr",     wr_addr,  32'(m_burst * BB));
      if (exp_vld) begin
        chk("data", wr_data, m_q[0]);
        chk("last", wr_last, m_beats == BL - 1);
      end else begin
        chk("last_idle", wr_last, 1'b0);
      end
      if (!rst_n) begin
        chk("data_rst", wr_data, '0);
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          n_stall_seen++;
          chk("stall_valid", wr_valid, 1'b1);
          chk("stall_data",  wr_data,  prev_dat);
          chk("stall_last",  wr_last,  prev_last);
        end
        if (wr_valid && wr_ready) begin
          acc_dat.push_back(wr_data);
          acc_lst.push_back(wr_last);
        end
        if (wr_req && wr_ack) req_addr.push_back(wr_addr);
        prev_stall = wr_valid && !wr_ready;
        prev_dat   = wr_data;
        prev_last  = wr_last;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit tog = 0;

  task automatic tick();
    @(negedge clk);
    if (tog) wr_ready = ~wr_ready;
  endtask

  task automatic send(int base, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      user_valid = 1'b1;
      user_data  = 16'(base + i);
    end
    tick();
    user_valid = 1'b0;
  endtask

  task automatic wait_beats(string nm, int n, int budget);
    int c = 0;
    while (acc_dat.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(nm, 128'(acc_dat.size() >= n), 128'(1));
  endtask

  task automatic clear_logs();
    acc_dat.delete();
    acc_lst.delete();
    req_addr.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_req"},   wr_req,   1'b0);
    chk({nm, "_valid"}, wr_valid, 1'b0);
    chk({nm, "_last"},  wr_last,  1'b0);
    chk({nm, "_ovf"},   overflow, 1'b0);
    chk({nm, "_data"},  wr_data,  '0);
    chk({nm, "_addr"},  wr_addr,  32'h0);
    chk({nm, "_len"},   wr_len,   8'd15);
  endtask

  // Checks beats [0..n) hold consecutive words starting at word value w0.
  task automatic chk_seq(string nm, int n, int w0);
    logic [127:0] e;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < R; k++) e[k*16 +: 16] = 16'(w0 + b*R + k);
      if (b < acc_dat.size()) chk(nm, acc_dat[b], e);
      else chk(nm, '0, e);
    end
  endtask

  logic [127:0] b0;
  logic [127:0] b15;
  int           n_last;

  initial begin
    rst_n = 1'b0; user_valid = 1'b0; user_data = '0; wr_ack = 1'b0; wr_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");

    // First burst: words 0..127
    @(negedge clk);
    rst_n = 1'b1; wr_ack = 1'b1; wr_ready = 1'b1;
    clear_logs();
    send(0, 128);
    wait_beats("first_burst_done", 16, 200);
    b0  = (acc_dat.size() > 0)  ? acc_dat[0]  : '0;
    b15 = (acc_dat.size() > 15) ? acc_dat[15] : '0;
    chk("first_addr",   (req_addr.size() > 0) ? req_addr[0] : 32'hFFFF_FFFF, 32'h0);
    chk("beat0_lane0",  b0[15:0],    16'h0000);
    chk("beat0_lane7",  b0[127:112], 16'h0007);
    chk("beat15_lane7", b15[127:112], 16'h007F);
    chk("beat15_last",  (acc_lst.size() > 15) ? acc_lst[15] : 1'b0, 1'b1);
    chk("beat0_last",   (acc_lst.size() > 0) ? acc_lst[0] : 1'b1, 1'b0);

    // Rest of the frame plus first burst of the next frame
    send(128, 4096 - 128);
    send(4096, 128);
    wait_beats("frame_done", 16 * 33, 2000);
    chk("frame_bursts", 128'(req_addr.size()), 128'(33));
    for (int k = 0; k < 33 && k < req_addr.size(); k++)
      chk("frame_addr", req_addr[k], 32'((k % 32) * 256));
    chk("frame_ovf", overflow, 1'b0);
    chk_seq("frame_data", 16 * 33, 0);

    // Overflow: no grant while 520 words arrive
    wr_ack = 1'b0;
    do_reset();
    send(0, 520);
    repeat (5) tick();
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_no_beats", 128'(acc_dat.size()), 128'(0));
    wr_ack = 1'b1;
    wait_beats("ovf_drain", 64, 400);
    repeat (40) tick();
    chk("ovf_beat_count", 128'(acc_dat.size()), 128'(64));
    chk_seq("ovf_data", 64, 0);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_addr3", (req_addr.size() > 3) ? req_addr[3] : 32'hFFFF_FFFF, 32'h300);

    // Ready toggling every cycle during the burst
    do_reset();
    wr_ready = 1'b1;
    tog = 1;
    send(0, 128);
    wait_beats("stall_done", 16, 300);
    tog = 0;
    wr_ready = 1'b1;
    chk("stall_seen", 128'(n_stall_seen > 0), 128'(1));
    n_last = 0;
    foreach (acc_lst[i]) if (acc_lst[i]) n_last++;
    chk("stall_nlast", 128'(n_last), 128'(1));
    chk("stall_last16", (acc_lst.size() > 15) ? acc_lst[15] : 1'b0, 1'b1);
    chk_seq("stall_data", 16, 0);

    // Reset mid-burst (beat 7) with a 3-word partial beat pending
    do_reset();
    wr_ready = 1'b0;
    send(0, 131);
    repeat (4) tick();
    wr_ready = 1'b1;
    begin
      int c = 0;
      while (acc_dat.size() < 7 && c < 100) begin
        tick();
        c++;
      end
    end
    chk("midrst_reached_b7", 128'(acc_dat.size()), 128'(7));
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    tick();
    rst_n = 1'b1;
    clear_logs();
    send(1000, 127);
    repeat (10) tick();
    chk("midrst_no_req", 128'(req_addr.size()), 128'(0));
    chk("midrst_no_beat", 128'(acc_dat.size()), 128'(0));
    send(1127, 1);
    wait_beats("midrst_burst", 16, 200);
    chk_seq("midrst_data", 16, 1000);
    chk("midrst_addr", (req_addr.size() > 0) ? req_addr[0] : 32'hFFFF_FFFF, 32'h0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/user_wr_packer.md
USER_WR_PACKER -- requirements
Module: user_wr_packer

Interface
REQ-001 SHALL have parameter P_USER_DATA_WIDTH, default 16: width of user write words.
REQ-002 SHALL have parameter P_AXI_DATA_WIDTH, default 128: width of packed write beats; integer multiple of P_USER_DATA_WIDTH (ratio R = 8 at defaults).
REQ-003 SHALL have parameter P_AXI_ADDR_WIDTH, default 32: write address width.
REQ-004 SHALL have parameter P_WR_LENGTH, default 4096: user words per frame; frame bytes = P_WR_LENGTH*P_USER_DATA_WIDTH/8.
REQ-005 SHALL have parameter P_BURST_LEN, default 16: beats per write burst.
REQ-006 SHALL have parameter P_FIFO_DEPTH, default 64: beat buffer depth, power of two, >= 2*P_BURST_LEN.
REQ-007 SHALL have parameter P_BASE_ADDR, default 0: byte address of frame start.
REQ-008 i_clk  in  1  single clock for all logic.
REQ-009 i_rst  in  1  asynchronous, active-low reset.
REQ-010 i_user_data  in  P_USER_DATA_WIDTH  user write word.
REQ-011 i_user_valid  in  1  word qualifier; no backpressure exists on this side.
REQ-012 o_wr_req  out  1  burst request, held until i_wr_ack.
REQ-013 o_wr_addr  out  P_AXI_ADDR_WIDTH  burst start byte address, stable while o_wr_req=1.
REQ-014 o_wr_len  out  8  burst length minus one (P_BURST_LEN-1).
REQ-015 i_wr_ack  in  1  request accepted when o_wr_req & i_wr_ack.
REQ-016 o_wr_data  out  P_AXI_DATA_WIDTH  write beat.
REQ-017 o_wr_valid  out  1  beat qualifier.
REQ-018 o_wr_last  out  1  final beat of burst.
REQ-019 i_wr_ready  in  1  beat accepted when o_wr_valid & i_wr_ready.
REQ-020 o_overflow  out  1  sticky: a packed beat was dropped.

Function
REQ-021 Packing: SHALL accept a word every cycle i_user_valid=1; word k (0..R-1) of a beat placed at bits [k*W+W-1 : k*W], first word in lowest lane.
REQ-022 Beat SHALL be pushed into buffer the cycle after its R-th word is accepted (1-cycle latency); pack counter wraps R-1 -> 0 with no bubble.
REQ-023 Buffer full at push time: beat SHALL be dropped, o_overflow set to 1 and held until reset; buffer contents unaffected.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and is legal at full (pop frees slot same cycle, push accepted).
REQ-025 FSM states IDLE, REQ, DATA; IDLE -> REQ when buffer count >= P_BURST_LEN; REQ -> DATA on i_wr_ack; DATA -> IDLE on accepted beat with o_wr_last=1.
REQ-026 o_wr_req=1 exactly in REQ; o_wr_valid=1 in DATA whenever buffer non-empty (always, given REQ-025 entry rule).
REQ-027 o_wr_data SHALL be buffer head (first-in-first-out); beat data/last SHALL hold stable while o_wr_valid & !i_wr_ready.
REQ-028 Beat counter counts accepted beats in DATA; o_wr_last=1 on beat P_BURST_LEN-1 only.
REQ-029 o_wr_addr SHALL start at P_BASE_ADDR and advance by P_BURST_LEN*P_AXI_DATA_WIDTH/8 after each completed burst; after the burst ending at frame end it SHALL wrap to P_BASE_ADDR.
REQ-030 Partial beat words SHALL never be emitted; a partial beat persists until completed.

Reset
REQ-031 While i_rst=0: FSM IDLE, buffer empty, pack counter 0, beat counter 0, address P_BASE_ADDR; o_wr_req, o_wr_valid, o_wr_last, o_overflow = 0; o_wr_data = 0; o_wr_addr = P_BASE_ADDR; o_wr_len = P_BURST_LEN-1.
REQ-032 Reset asserted mid-burst or mid-pack SHALL discard all buffered and partial data; no request or beat after release until 128 new words arrive (defaults).

Verification
REQ-033 Release reset, drive words 0..127 consecutively, i_wr_ack=1, i_wr_ready=1 -> one request addr 0x0 len 15; beat0 [15:0]=0x0000, [127:112]=0x0007; beat15 [127:112]=0x007F with o_wr_last=1.
REQ-034 Stream full frame 4096 words, sinks always ready -> 32 bursts at 0x0000, 0x0100, ... 0x1F00; next frame's first burst at 0x0000; o_overflow stays 0.
REQ-035 Hold i_wr_ack=0, stream 520 words -> buffer holds 64 beats; 65th beat dropped, o_overflow=1 and remains 1; released bursts carry words 0..511 only.
REQ-036 Toggle i_wr_ready 1-0 per cycle during a burst -> each beat held stable while stalled; 16 beats accepted, o_wr_last only on 16th.
REQ-037 Assert i_rst=0 at beat 7 of a burst and mid-pack (word 3) -> outputs return to reset values immediately; after release, first beat contains only post-reset words in order.
